// File: rtl/gray2bcd_deser.sv
// gray2bcd_deser
//
// Receives a frame of DIGITS Gray-coded digits bit-serially, MSB first.
// Each 4-bit Gray digit is converted to binary as its bits arrive, and the
// decoded digits are packed into a BCD word. Any digit that decodes to
// 10..15 sets err for that frame.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      frame start pulse; accepted in any state (aborts a frame in RECV)
//   bit_in     serial Gray bit, MSB of the most-significant digit first
//   bit_valid  qualifies bit_in; one bit per cycle is taken while in RECV
//   busy       high while a frame is being received
//   bcd_out    packed result; first received digit in the MSBs
//   out_valid  one-cycle pulse when bcd_out/err hold a new result
//   err        last completed frame contained a digit above 9
module gray2bcd_deser #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  err
);

  localparam int NBITS = DIGITS * 4;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // A digit is outside the BCD range when it decodes to 10..15.
  function automatic logic is_non_bcd(input logic [3:0] v);
    return (v > 4'd9);
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  x_q, x_d;
  // Only the first three decoded bits of a digit need storing; the fourth
  // is used directly when the digit completes.
  logic [2:0]            work_q, work_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic                  sticky_q, sticky_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;

  logic                  x_eff;
  logic                  b;
  logic [3:0]            v;
  logic [4*DIGITS+3:0]   res_ext;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    work_d      = work_q;
    res_d       = res_q;
    sticky_d    = sticky_q;
    bcd_d       = bcd_q;
    err_d       = err_q;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;
    x_eff       = 1'b0;
    b           = 1'b0;
    v           = 4'd0;
    res_ext     = '0;

    if (start) begin
      // Start wins in every state: begin (or restart) a frame from bit 0.
      // bcd_out/err keep the previous result until the next DONE.
      state_d  = RECV;
      cnt_d    = '0;
      x_d      = 1'b0;
      work_d   = '0;
      res_d    = '0;
      sticky_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        RECV: begin
          busy_d = 1'b1;
          if (bit_valid) begin
            // Gray-to-binary: each binary bit is the XOR of all Gray bits
            // above it within the digit, so the running XOR restarts per digit.
            x_eff  = (cnt_q[1:0] == 2'd0) ? 1'b0 : x_q;
            b      = x_eff ^ bit_in;
            x_d    = b;
            work_d = {work_q[1:0], b};
            cnt_d  = cnt_q + CNT_W'(1);

            if (cnt_q[1:0] == 2'd3) begin
              v        = {work_q, b};
              res_ext  = {res_q, v};
              res_d    = res_ext[4*DIGITS-1:0];
              sticky_d = sticky_q | is_non_bcd(v);
              x_d      = 1'b0;

              if (cnt_q == LAST_BIT) begin
                state_d     = DONE;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                bcd_d       = res_d;
                err_d       = sticky_d;
              end
            end
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= 1'b0;
      work_q      <= '0;
      res_q       <= '0;
      sticky_q    <= 1'b0;
      bcd_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      work_q      <= work_d;
      res_q       <= res_d;
      sticky_q    <= sticky_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_out   = bcd_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gray2bcd_deser.sv
// Testbench for gray2bcd_deser (DIGITS=2): directed frames plus randomized
// frames and bit_valid gaps, checked against a behavioural Gray decoding model.
module tb_gray2bcd_deser;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic [W-1:0] bcd_out;
  logic         out_valid;
  logic         err;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_bcd;
  logic         last_err;

  always #5 clk = ~clk;

  gray2bcd_deser #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .err       (err)
  );

  // Binary bit i is the parity of Gray bits i..3.
  function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
    logic [3:0] r;
    int         parity;
    parity = 0;
    r      = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      parity = parity + int'(g[i]);
      r[i]   = (parity % 2 == 1);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_bcd(input logic [W-1:0] frame);
    logic [W-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) r[d*4 +: 4] = gray_to_bin(frame[d*4 +: 4]);
    return r;
  endfunction

  function automatic logic model_err(input logic [W-1:0] frame);
    logic e;
    e = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (int'(gray_to_bin(frame[d*4 +: 4])) > 9) e = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the top nbits of frame, MSB first, with optional random idle gaps.
  task automatic send_bits(input logic [W-1:0] frame, input int nbits, input int maxgap);
    int gap;
    for (int i = 0; i < nbits; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      bit_valid = 1'b0;
      repeat (gap) tick();
      bit_valid = 1'b1;
      bit_in    = frame[W-1-i];
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (i != W - 1) check("out_valid_mid_frame", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] frame);
    logic [W-1:0] eb;
    logic         ee;
    eb = model_bcd(frame);
    ee = model_err(frame);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
    check({tag, "_err"}, 32'(err), 32'(ee));
    last_bcd = eb;
    last_err = ee;
  endtask

  task automatic do_frame(input string tag, input logic [W-1:0] frame, input int maxgap);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_bcd_hold"}, 32'(bcd_out), 32'(last_bcd));
    check({tag, "_err_hold"}, 32'(err), 32'(last_err));
    send_bits(frame, W, maxgap);
    check_done(tag, frame);
    tick();
    check({tag, "_out_valid_1cyc"}, 32'(out_valid), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] f;
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    last_bcd  = '0;
    last_err  = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // bit_valid in IDLE does nothing.
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (10) tick();
    bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // 1..3: directed frames.
    do_frame("t1", 8'b0000_1101, 0);
    check("t1_const", 32'(last_bcd), 32'h09);
    do_frame("t2", 8'b0010_0100, 0);
    check("t2_const", 32'(last_bcd), 32'h37);
    do_frame("t3a", 8'b1111_0000, 0);
    check("t3a_const", 32'({last_err, last_bcd}), 32'h1A0);
    do_frame("t3b", 8'b0001_0011, 0);
    check("t3b_const", 32'({last_err, last_bcd}), 32'h012);

    // 4: same as test 2 with random gaps.
    for (int k = 0; k < 4; k++) do_frame("t4", 8'b0010_0100, 5);

    // 5: abort after 3 bits; bit_valid in the start cycle is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'b1111_1111, 3, 0);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_ov", 32'(out_valid), 32'd0);
    send_bits(8'b0110_0111, W, 0);
    check_done("t5", 8'b0110_0111);
    check("t5_const", 32'(bcd_out), 32'h45);
    // start held in DONE: straight back into RECV.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_b2b_busy", 32'(busy), 32'd1);
    check("t5_b2b_ov", 32'(out_valid), 32'd0);
    check("t5_b2b_bcd_hold", 32'(bcd_out), 32'h45);
    send_bits(8'b0010_0100, W, 2);
    check_done("t5_b2b", 8'b0010_0100);
    tick();
    check("t5_b2b_ov_1cyc", 32'(out_valid), 32'd0);

    // 6: reset mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(8'b1010_1010, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_bcd", 32'(bcd_out), 32'd0);
    check("t6_ov", 32'(out_valid), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    last_bcd = '0;
    last_err = 1'b0;
    send_bits(8'b0110_0111, W - 1, 0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    check("t6_no_ov", 32'(out_valid), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

    // Randomized frames with random gaps.
    for (int k = 0; k < 24; k++) begin
      f = W'($urandom);
      do_frame("rnd", f, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
